// File: rtl/vend_change_ctrl.sv
// vend_change_ctrl: coin-operated vending controller with change return.
// Credit is held in 5-cent units. When credit reaches PRICE_UNITS, one item
// is released and any overpayment is returned greedily as dimes, then nickels.
// A cancel refunds the whole credit. A saturating counter tracks completed vends.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   coin_valid  one coin presented this cycle
//   coin_type   00 nickel (1), 01 dime (2), 10 quarter (5), 11 slug (invalid)
//   cancel      customer refund request (honoured in COLLECT only)
//   coin_ready  controller accepts coins this cycle (state == COLLECT)
//   vend        one-cycle item-release pulse
//   dime_out    return one dime this cycle
//   nickel_out  return one nickel this cycle
//   reject      registered pulse: previous cycle's coin was not accepted
//   credit      current credit in units (post-edge value)
//   sales       completed vends, saturating at all-ones
module vend_change_ctrl #(
  parameter int unsigned PRICE_UNITS = 3,
  parameter int unsigned CREDIT_W    = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                cancel,
  output logic                coin_ready,
  output logic                vend,
  output logic                dime_out,
  output logic                nickel_out,
  output logic                reject,
  output logic [CREDIT_W-1:0] credit,
  output logic [CNT_W-1:0]    sales
);

  localparam int unsigned SUM_W = CREDIT_W + 1;
  localparam logic [SUM_W-1:0] PRICE_SUM = SUM_W'(PRICE_UNITS);
  localparam logic [CNT_W-1:0] SALES_MAX = '1;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    CHANGE  = 2'd2
  } state_t;

  state_t           state;
  logic [SUM_W-1:0] coin_val;
  logic [SUM_W-1:0] sum;
  logic             coin_ok;

  // Coin value decode; slugs carry no value and are flagged as not ok.
  always_comb begin
    coin_val = '0;
    case (coin_type)
      2'b00:   coin_val = SUM_W'(1);
      2'b01:   coin_val = SUM_W'(2);
      2'b10:   coin_val = SUM_W'(5);
      default: coin_val = '0;
    endcase
  end

  assign coin_ok = coin_valid && (coin_type != 2'b11);
  // One extra bit so a quarter on top of the largest collect credit cannot wrap.
  assign sum     = SUM_W'(credit) + coin_val;

  // Outputs decoded from registered state and credit only.
  assign coin_ready = (state == COLLECT);
  assign vend       = (state == VEND);
  assign dime_out   = (state == CHANGE) && (credit >= CREDIT_W'(2));
  assign nickel_out = (state == CHANGE) && (credit <  CREDIT_W'(2));

  // Controller state, credit, sales counter and reject flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= COLLECT;
      credit <= '0;
      sales  <= '0;
      reject <= 1'b0;
    end else begin
      // Any coin outside COLLECT, or a slug anywhere, is bounced next cycle.
      reject <= coin_valid && ((coin_type == 2'b11) || (state != COLLECT));

      case (state)
        COLLECT: begin
          if (coin_ok) begin
            if (sum >= PRICE_SUM) begin
              // Completing coin wins over a simultaneous cancel.
              credit <= CREDIT_W'(sum - PRICE_SUM);
              state  <= VEND;
            end else begin
              credit <= CREDIT_W'(sum);
              if (cancel) begin
                state <= CHANGE;
              end
            end
          end else if (cancel && (credit != '0)) begin
            state <= CHANGE;
          end
        end

        VEND: begin
          if (sales != SALES_MAX) begin
            sales <= sales + CNT_W'(1);
          end
          state <= (credit != '0) ? CHANGE : COLLECT;
        end

        CHANGE: begin
          // Greedy: dimes while at least two units remain, then one nickel.
          if (credit >= CREDIT_W'(2)) begin
            credit <= credit - CREDIT_W'(2);
            if (credit == CREDIT_W'(2)) begin
              state <= COLLECT;
            end
          end else begin
            credit <= '0;
            state  <= COLLECT;
          end
        end

        default: begin
          state  <= COLLECT;
          credit <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_change_ctrl.sv
// Self-checking bench for vend_change_ctrl: a vector table and hand sequences
// on a PRICE_UNITS=3 instance, hand sequences on a PRICE_UNITS=1 / CNT_W=2
// instance, then randomized traffic on both against a transaction-level model.
module tb_vend_change_ctrl;

  logic clk;
  logic rst0, cv0, can0;
  logic [1:0] ct0;
  logic rdy0, v0, d0, n0, rj0;
  logic [3:0] cr0;
  logic [7:0] s0;

  logic rst1, cv1, can1;
  logic [1:0] ct1;
  logic rdy1, v1, d1, n1, rj1;
  logic [3:0] cr1;
  logic [1:0] s1;

  int checks = 0;
  int errors = 0;

  vend_change_ctrl #(.PRICE_UNITS(3), .CREDIT_W(4), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst0), .coin_valid(cv0), .coin_type(ct0), .cancel(can0),
    .coin_ready(rdy0), .vend(v0), .dime_out(d0), .nickel_out(n0),
    .reject(rj0), .credit(cr0), .sales(s0)
  );

  vend_change_ctrl #(.PRICE_UNITS(1), .CREDIT_W(4), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst1), .coin_valid(cv1), .coin_type(ct1), .cancel(can1),
    .coin_ready(rdy1), .vend(v1), .dime_out(d1), .nickel_out(n1),
    .reject(rj1), .credit(cr1), .sales(s1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: credit held while collecting, a pending-vend flag, and
  // the refund expressed as counts of dimes and nickels still to be paid out.
  int m_held[2];
  int m_dimes[2];
  int m_nick[2];
  int m_sales[2];
  bit m_vp[2];
  bit m_rej[2];
  int price[2] = '{3, 1};
  int smax[2]  = '{255, 3};

  function automatic bit m_ready(int u);
    return !m_vp[u] && (m_dimes[u] == 0) && (m_nick[u] == 0);
  endfunction

  function automatic void m_refund(int u);
    m_dimes[u] = m_held[u] / 2;
    m_nick[u]  = m_held[u] % 2;
    m_held[u]  = 0;
  endfunction

  function automatic void m_step(int u, bit r, bit cv, logic [1:0] ty, bit can);
    int val;
    bit rdy;
    rdy = m_ready(u);
    if (r) begin
      m_held[u] = 0; m_dimes[u] = 0; m_nick[u] = 0;
      m_sales[u] = 0; m_vp[u] = 0; m_rej[u] = 0;
      return;
    end
    m_rej[u] = cv && ((ty == 2'b11) || !rdy);
    if (m_vp[u]) begin
      m_vp[u] = 0;
      if (m_sales[u] < smax[u]) m_sales[u]++;
      m_refund(u);
    end else if (m_dimes[u] > 0) begin
      m_dimes[u]--;
    end else if (m_nick[u] > 0) begin
      m_nick[u]--;
    end else if (cv && (ty != 2'b11)) begin
      val = (ty == 2'b00) ? 1 : (ty == 2'b01) ? 2 : 5;
      if (m_held[u] + val >= price[u]) begin
        m_held[u] = m_held[u] + val - price[u];
        m_vp[u] = 1;
      end else begin
        m_held[u] = m_held[u] + val;
        if (can) m_refund(u);
      end
    end else if (can && (m_held[u] > 0)) begin
      m_refund(u);
    end
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(int u, string tag, int cr, int v, int d, int n,
                         int rdy, int rej, int s);
    if (u == 0) begin
      chk({tag, " credit"}, cr0, cr);   chk({tag, " vend"}, v0, v);
      chk({tag, " dime"}, d0, d);       chk({tag, " nickel"}, n0, n);
      chk({tag, " ready"}, rdy0, rdy);  chk({tag, " reject"}, rj0, rej);
      chk({tag, " sales"}, s0, s);
    end else begin
      chk({tag, " credit"}, cr1, cr);   chk({tag, " vend"}, v1, v);
      chk({tag, " dime"}, d1, d);       chk({tag, " nickel"}, n1, n);
      chk({tag, " ready"}, rdy1, rdy);  chk({tag, " reject"}, rj1, rej);
      chk({tag, " sales"}, s1, s);
    end
  endtask

  task automatic chk_model(int u);
    string tag;
    tag = (u == 0) ? "rnd0" : "rnd1";
    chk_all(u, tag, m_held[u] + 2 * m_dimes[u] + m_nick[u], int'(m_vp[u]),
            int'(!m_vp[u] && m_dimes[u] > 0),
            int'(!m_vp[u] && m_dimes[u] == 0 && m_nick[u] > 0),
            int'(m_ready(u)), int'(m_rej[u]), m_sales[u]);
  endtask

  task automatic drive0(bit r, bit cv, logic [1:0] ty, bit can);
    rst0 = r; cv0 = cv; ct0 = ty; can0 = can;
  endtask

  task automatic drive1(bit r, bit cv, logic [1:0] ty, bit can);
    rst1 = r; cv1 = cv; ct1 = ty; can1 = can;
  endtask

  // One clock: model follows the inputs sampled at the edge; outputs settle by #1.
  task automatic tick();
    @(posedge clk);
    m_step(0, rst0, cv0, ct0, can0);
    m_step(1, rst1, cv1, ct1, can1);
    #1;
  endtask

  typedef struct {
    bit cv; logic [1:0] ty; bit can;
    int cr; int v; int d; int n; int rdy; int rej; int s;
  } vec_t;

  function automatic vec_t mk(bit cv, logic [1:0] ty, bit can, int cr, int v,
                              int d, int n, int rdy, int rej, int s);
    vec_t t;
    t.cv = cv; t.ty = ty; t.can = can; t.cr = cr; t.v = v; t.d = d;
    t.n = n; t.rdy = rdy; t.rej = rej; t.s = s;
    return t;
  endfunction

  localparam logic [1:0] NK = 2'b00, DM = 2'b01, QT = 2'b10, SL = 2'b11;

  vec_t tv[24];
  int dimes, nicks, cyc;

  initial begin
    //          cv ty  can  cr v d n rdy rej s
    tv[0]  = mk(1, NK, 0,   1, 0,0,0, 1, 0, 0);
    tv[1]  = mk(1, NK, 0,   2, 0,0,0, 1, 0, 0);
    tv[2]  = mk(1, NK, 0,   0, 1,0,0, 0, 0, 0);
    tv[3]  = mk(0, NK, 0,   0, 0,0,0, 1, 0, 1);
    tv[4]  = mk(1, DM, 0,   2, 0,0,0, 1, 0, 1);
    tv[5]  = mk(1, QT, 0,   4, 1,0,0, 0, 0, 1);
    tv[6]  = mk(0, NK, 0,   4, 0,1,0, 0, 0, 2);
    tv[7]  = mk(0, NK, 0,   2, 0,1,0, 0, 0, 2);
    tv[8]  = mk(0, NK, 0,   0, 0,0,0, 1, 0, 2);
    tv[9]  = mk(1, NK, 0,   1, 0,0,0, 1, 0, 2);
    tv[10] = mk(1, DM, 1,   0, 1,0,0, 0, 0, 2);  // completing coin beats cancel
    tv[11] = mk(0, NK, 0,   0, 0,0,0, 1, 0, 3);
    tv[12] = mk(1, NK, 0,   1, 0,0,0, 1, 0, 3);
    tv[13] = mk(1, NK, 1,   2, 0,1,0, 0, 0, 3);  // refund includes this coin
    tv[14] = mk(0, NK, 0,   0, 0,0,0, 1, 0, 3);
    tv[15] = mk(1, SL, 0,   0, 0,0,0, 1, 1, 3);
    tv[16] = mk(1, DM, 0,   2, 0,0,0, 1, 0, 3);
    tv[17] = mk(1, NK, 0,   0, 1,0,0, 0, 0, 3);
    tv[18] = mk(1, NK, 0,   0, 0,0,0, 1, 1, 4);  // coin during VEND bounced
    tv[19] = mk(0, NK, 0,   0, 0,0,0, 1, 0, 4);
    tv[20] = mk(0, NK, 1,   0, 0,0,0, 1, 0, 4);  // cancel with no credit
    tv[21] = mk(1, NK, 0,   1, 0,0,0, 1, 0, 4);
    tv[22] = mk(1, SL, 1,   1, 0,0,1, 0, 1, 4);  // slug plus cancel refunds
    tv[23] = mk(0, NK, 0,   0, 0,0,0, 1, 0, 4);

    drive0(1, 0, NK, 0);
    drive1(1, 0, NK, 0);
    tick(); tick();
    drive0(0, 0, NK, 0);
    drive1(0, 0, NK, 0);
    chk_all(0, "reset0", 0, 0, 0, 0, 1, 0, 0);
    chk_all(1, "reset1", 0, 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < 24; i++) begin
      drive0(0, tv[i].cv, tv[i].ty, tv[i].can);
      tick();
      chk_all(0, $sformatf("vec%0d", i), tv[i].cr, tv[i].v, tv[i].d, tv[i].n,
              tv[i].rdy, tv[i].rej, tv[i].s);
    end
    drive0(0, 0, NK, 0);

    // Quarter at price 1: remainder 4 returns as exactly two dimes.
    drive1(0, 1, QT, 0);
    tick();
    chk_all(1, "q_vend", 4, 1, 0, 0, 0, 0, 0);
    drive1(0, 0, NK, 0);
    dimes = 0; nicks = 0; cyc = 0;
    do begin
      tick();
      cyc++;
      if (d1) dimes++;
      if (n1) nicks++;
    end while (!rdy1 && cyc < 10);
    chk("q_ready", rdy1, 1);
    chk("q_dimes", dimes, 2);
    chk("q_nickels", nicks, 0);
    chk("q_credit", cr1, 0);

    // Five more vends saturate the 2-bit sales counter.
    for (int k = 0; k < 5; k++) begin
      drive1(0, 1, NK, 0);
      tick();
      chk($sformatf("sat_vend%0d", k), v1, 1);
      drive1(0, 0, NK, 0);
      tick();
    end
    chk("sat_sales", s1, 3);

    // Reset during the second cycle of a 4-unit change payout.
    drive0(0, 1, DM, 0); tick();
    drive0(0, 1, QT, 0); tick();
    chk("mid_vend", v0, 1);
    drive0(0, 0, NK, 0); tick();
    chk_all(0, "chg1", 4, 0, 1, 0, 0, 0, 5);
    tick();
    chk_all(0, "chg2", 2, 0, 1, 0, 0, 0, 5);
    drive0(1, 0, NK, 0); tick();
    drive0(0, 0, NK, 0);
    chk_all(0, "mid_rst", 0, 0, 0, 0, 1, 0, 0);

    // Randomized traffic on both instances against the model.
    for (int i = 0; i < 3000; i++) begin
      drive0($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6,
             2'($urandom_range(0, 3)), $urandom_range(0, 9) < 2);
      drive1($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6,
             2'($urandom_range(0, 3)), $urandom_range(0, 9) < 2);
      tick();
      chk_model(0);
      chk_model(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
